// File: rtl/mem_rsp_pkg.sv
// Shared types and constants for the mem_responder data-memory responder.
package mem_rsp_pkg;

    localparam int WORD_W    = 16;
    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Stores and misaligned accesses return zero data.
    function automatic logic [WORD_W-1:0] rsp_data(input logic wr,
                                                   input logic bad,
                                                   input logic [WORD_W-1:0] rd);
        return (wr || bad) ? '0 : rd;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU data-memory request/response bundle; master = CPU memory stage, slave = responder.
interface mem_responder_if;
    import mem_rsp_pkg::*;

    logic              req_en;
    logic              req_wr;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_en, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_en, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/mem_rsp_array.sv
// Word-addressed storage: synchronous write, combinational read, no reset of contents.
module mem_rsp_array
    import mem_rsp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency load/store responder for the CPU data-memory port.
// Optional MEMRSP_STALL_CNT_EN adds a saturating stall_cnt output.
module mem_responder
    import mem_rsp_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_responder_if.slave bus
`ifdef MEMRSP_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    localparam bit                   DIRECT_LAT = (LATENCY == 1);
    localparam logic [LAT_CNT_W-1:0] LAT_M1     = LAT_CNT_W'(LATENCY - 1);

    state_t               state;
    logic [LAT_CNT_W-1:0] cnt;
    logic                 ready_q;
    logic                 busy_q;
    logic                 rsp_valid_q;
    logic [WORD_W-1:0]    rdata_q;
    logic                 err_q;

    logic                 lat_wr;
    logic [ADDR_W:0]      lat_addr;
    logic [WORD_W-1:0]    lat_wdata;

    logic                 accept;
    logic                 acc_fire;
    logic                 acc_wr;
    logic                 acc_bad;
    logic [ADDR_W:0]      acc_addr;
    logic [WORD_W-1:0]    acc_wdata;
    logic                 mem_we;
    logic [WORD_W-1:0]    mem_rdata;
    logic                 unused_addr_hi;

    // Address bits above the word index alias and are deliberately dropped.
    assign unused_addr_hi = ^bus.req_addr[WORD_W-1:ADDR_W+1];

    // With LATENCY == 1 the accept edge is also the access edge, so the
    // access uses the live request rather than the latched copy.
    always_comb begin
        accept    = bus.req_en && ready_q && !rst;
        acc_fire  = 1'b0;
        acc_wr    = lat_wr;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (DIRECT_LAT) begin
            acc_fire  = accept;
            acc_wr    = bus.req_wr;
            acc_addr  = bus.req_addr[ADDR_W:0];
            acc_wdata = bus.req_wdata;
        end else begin
            acc_fire  = !rst && (state == BUSY) && (cnt == LAT_CNT_W'(1));
        end
        acc_bad = acc_addr[0];
        mem_we  = acc_fire && acc_wr && !acc_bad;
    end

    mem_rsp_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (acc_addr[ADDR_W:1]),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    // Request fields are data only; they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_wr    <= bus.req_wr;
            lat_addr  <= bus.req_addr[ADDR_W:0];
            lat_wdata <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= acc_fire;
            if (acc_fire) begin
                rdata_q <= rsp_data(acc_wr, acc_bad, mem_rdata);
                err_q   <= acc_bad;
            end
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (DIRECT_LAT) begin
                            state   <= RESP;
                            ready_q <= 1'b1;
                        end else begin
                            state   <= BUSY;
                            cnt     <= LAT_M1;
                            ready_q <= 1'b0;
                        end
                    end else begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt == LAT_CNT_W'(1)) begin
                        state   <= RESP;
                        cnt     <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

`ifdef MEMRSP_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (bus.req_en && !ready_q && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (LATENCY=4, ADDR_W=10); covers stall_cnt when MEMRSP_STALL_CNT_EN is defined.
module tb_mem_responder;

    localparam int LAT = 4;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_responder_if bus ();
`ifdef MEMRSP_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    mem_responder #(
        .ADDR_W  (10),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave)
`ifdef MEMRSP_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive a request at the current negedge while req_ready is known high.
    task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d);
        bus.req_en    = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk);
        #1 bus.req_en = 1'b0;
    endtask

    // Returns at the negedge of the response cycle; cyc counts negedges since accept.
    task automatic wait_rsp(output int cyc, output int rdy_low, output logic busy1,
                            output logic [15:0] rd, output logic er);
        cyc = 0; rdy_low = 0; busy1 = 1'b0; rd = 'x; er = 1'bx;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = bus.busy;
            if (!bus.req_ready) rdy_low++;
            if (bus.rsp_valid) begin
                cyc = k;
                rd  = bus.rsp_rdata;
                er  = bus.rsp_err;
                break;
            end
        end
        if (cyc == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: got no rsp_valid within 50 cycles, want one");
        end
    endtask

    task automatic count_rsp(input int n, output int hits);
        hits = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) hits++;
        end
    endtask

    vec_t        vecs [13];
    int          cyc, rdy_low, hits;
    logic        busy1, er;
    logic [15:0] rd;

    initial begin
        total = 0;
        bad   = 0;
        bus.req_en    = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst = 1'b1;

        vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1};
        vecs[3]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[4]  = '{1'b1, 16'h0811, 16'h1234, 16'h0000, 1'b1};
        vecs[5]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[6]  = '{1'b1, 16'h0810, 16'hA5A5, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 16'h0010, 16'h0000, 16'hA5A5, 1'b0};
        vecs[8]  = '{1'b1, 16'h07FE, 16'h1357, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 16'hFFFE, 16'h0000, 16'h1357, 1'b0};
        vecs[10] = '{1'b1, 16'h0000, 16'h0F0F, 16'h0000, 1'b0};
        vecs[11] = '{1'b0, 16'h0000, 16'h0000, 16'h0F0F, 1'b0};
        vecs[12] = '{1'b0, 16'h07FE, 16'h0000, 16'h1357, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",     32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata",     32'(bus.rsp_rdata), 32'd0);
        chk("rst_err",       32'(bus.rsp_err),   32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready",    32'(bus.req_ready), 32'd1);
        chk("idle_busy",     32'(bus.busy),      32'd0);
        chk("idle_rsp",      32'(bus.rsp_valid), 32'd0);

        // Table: each request is issued in the previous response cycle.
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            wait_rsp(cyc, rdy_low, busy1, rd, er);
            chk($sformatf("v%0d_latency", i),  32'(cyc),     32'(LAT));
            chk($sformatf("v%0d_ready_lo", i), 32'(rdy_low), 32'(LAT - 1));
            chk($sformatf("v%0d_busy", i),     32'(busy1),   32'd1);
            chk($sformatf("v%0d_rdata", i),    32'(rd),      32'(vecs[i].exp_rdata));
            chk($sformatf("v%0d_err", i),      32'(er),      32'(vecs[i].exp_err));
        end

        // Read-after-write: load accepted in the store's response cycle.
        issue(1'b1, 16'h0020, 16'hCAFE);
        wait_rsp(cyc, rdy_low, busy1, rd, er);
        chk("raw_store_lat", 32'(cyc), 32'(LAT));
        issue(1'b0, 16'h0020, 16'h0000);
        wait_rsp(cyc, rdy_low, busy1, rd, er);
        chk("raw_load_lat",   32'(cyc), 32'(LAT));
        chk("raw_load_rdata", 32'(rd),  32'hCAFE);
        count_rsp(1, hits);
        chk("rsp_one_cycle", 32'(hits), 32'd0);

        // Reset two cycles after a store is accepted abandons it.
        @(negedge clk);
        issue(1'b1, 16'h0030, 16'h1111);
        wait_rsp(cyc, rdy_low, busy1, rd, er);
        @(negedge clk);
        issue(1'b1, 16'h0030, 16'h2222);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_rsp(6, hits);
        chk("rst_mid_no_rsp", 32'(hits),     32'd0);
        chk("rst_mid_busy",   32'(bus.busy), 32'd0);
        issue(1'b0, 16'h0030, 16'h0000);
        wait_rsp(cyc, rdy_low, busy1, rd, er);
        chk("rst_mid_rdata", 32'(rd), 32'h1111);

        // Request held while busy is ignored, not queued.
        issue(1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        bus.req_en    = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 16'hDEAD;
        wait_rsp(cyc, rdy_low, busy1, rd, er);
        bus.req_en = 1'b0;
        chk("ign_lat",   32'(cyc), 32'(LAT - 1));
        chk("ign_rdata", 32'(rd),  32'h0F0F);
        count_rsp(6, hits);
        chk("ign_no_rsp", 32'(hits), 32'd0);
        issue(1'b0, 16'h0000, 16'h0000);
        wait_rsp(cyc, rdy_low, busy1, rd, er);
        chk("ign_no_write", 32'(rd), 32'h0F0F);

`ifdef MEMRSP_STALL_CNT_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("stall_rst", stall_cnt, 32'd0);
        bus.req_en    = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 16'h0010;
        bus.req_wdata = 16'h0000;
        @(posedge clk);
        wait_rsp(cyc, rdy_low, busy1, rd, er);
        chk("stall_first_rdata", 32'(rd), 32'hA5A5);
        wait_rsp(cyc, rdy_low, busy1, rd, er);
        bus.req_en = 1'b0;
        chk("stall_second_lat", 32'(cyc), 32'(LAT));
        chk("stall_cnt", stall_cnt, 32'd6);
        @(negedge clk);
        chk("stall_cnt_hold", stall_cnt, 32'd6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
